// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: state encoding, datapath widths and the
// MEM/WB bubble value used while the pipeline is stalled.
package mem_access_unit_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
   } memwb_ctrl_t;

   localparam memwb_ctrl_t MEMWB_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-wait timeout counter: clear restarts the count, enable advances it,
// expire flags the final allowed wait cycle.
module mem_timeout_ctr #(
   parameter int LIMIT = 16,
   parameter int CNT_W = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LAST_C);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage responder: issues data-memory accesses over req/ack, stalls the
// upstream pipeline while busy and registers the MEM/WB payload.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regwrite_m,
   input  logic              memtoreg_m,
   input  logic              memwrite_m,
   input  logic              memread_m,
   input  logic [DATA_W-1:0] execout_m,
   input  logic [DATA_W-1:0] writedata_m,
   input  logic [REG_W-1:0]  writereg_m,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              mem_stall,
   output logic              regwrite_w,
   output logic              memtoreg_w,
   output logic [DATA_W-1:0] readdata_w,
   output logic [DATA_W-1:0] execout_w,
   output logic [REG_W-1:0]  writereg_w,
   output logic              bus_error
);

   mem_state_t        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic              err_q, err_d;
   memwb_ctrl_t       ctrl_q, ctrl_d;
   logic [DATA_W-1:0] rdw_q, rdw_d;
   logic [DATA_W-1:0] exw_q, exw_d;
   logic [REG_W-1:0]  wrw_q, wrw_d;
   logic              access;
   logic              ctr_clear, ctr_en, expire;

   mem_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (CNT_W)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (ctr_clear),
      .enable_i (ctr_en),
      .expire_o (expire)
   );

   always_comb begin
      access    = memread_m | memwrite_m;
      mem_stall = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ);
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cap_d     = cap_q;
      err_d     = err_q;
      ctrl_d    = ctrl_q;
      rdw_d     = rdw_q;
      exw_d     = exw_q;
      wrw_d     = wrw_q;
      ctr_clear = 1'b0;
      ctr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               state_d   = ST_REQ;
               req_d     = 1'b1;
               we_d      = memwrite_m;
               addr_d    = execout_m;
               wdata_d   = writedata_m;
               ctr_clear = 1'b1;
            end else begin
               ctrl_d.regwrite = regwrite_m;
               ctrl_d.memtoreg = memtoreg_m;
               rdw_d           = '0;
               exw_d           = execout_m;
               wrw_d           = writereg_m;
            end
         end
         ST_REQ: begin
            // A completing ack takes priority over a simultaneous timeout.
            if (dmem_ack) begin
               cap_d   = we_q ? '0 : dmem_rdata;
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else if (expire) begin
               cap_d   = '0;
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               ctr_en = 1'b1;
            end
         end
         ST_DONE: begin
            ctrl_d.regwrite = regwrite_m;
            ctrl_d.memtoreg = memtoreg_m;
            rdw_d           = cap_q;
            exw_d           = execout_m;
            wrw_d           = writereg_m;
            state_d         = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Stalled edges insert a bubble so writeback never repeats or runs early.
      if (mem_stall) begin
         ctrl_d = MEMWB_BUBBLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cap_q   <= '0;
         err_q   <= 1'b0;
         ctrl_q  <= MEMWB_BUBBLE;
         rdw_q   <= '0;
         exw_q   <= '0;
         wrw_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cap_q   <= cap_d;
         err_q   <= err_d;
         ctrl_q  <= ctrl_d;
         rdw_q   <= rdw_d;
         exw_q   <= exw_d;
         wrw_q   <= wrw_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign regwrite_w = ctrl_q.regwrite;
   assign memtoreg_w = ctrl_q.memtoreg;
   assign readdata_w = rdw_q;
   assign execout_w  = exw_q;
   assign writereg_w = wrw_q;
   assign bus_error  = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected MEM/WB results are queued when
// an operation is driven and compared when its writeback edge occurs.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        regwrite_m, memtoreg_m, memwrite_m, memread_m;
   logic [31:0] execout_m, writedata_m;
   logic [4:0]  writereg_m;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        mem_stall;
   logic        regwrite_w, memtoreg_w;
   logic [31:0] readdata_w, execout_w;
   logic [4:0]  writereg_w;
   logic        bus_error;

   typedef struct {
      logic        regwrite;
      logic        memtoreg;
      logic [31:0] readdata;
      logic [31:0] execout;
      logic [4:0]  writereg;
   } wb_t;

   wb_t sb[$];
   int  checks = 0;
   int  errors = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .regwrite_m  (regwrite_m),
      .memtoreg_m  (memtoreg_m),
      .memwrite_m  (memwrite_m),
      .memread_m   (memread_m),
      .execout_m   (execout_m),
      .writedata_m (writedata_m),
      .writereg_m  (writereg_m),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_ack    (dmem_ack),
      .mem_stall   (mem_stall),
      .regwrite_w  (regwrite_w),
      .memtoreg_w  (memtoreg_w),
      .readdata_w  (readdata_w),
      .execout_w   (execout_w),
      .writereg_w  (writereg_w),
      .bus_error   (bus_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_nop();
      regwrite_m  = 1'b0;
      memtoreg_m  = 1'b0;
      memwrite_m  = 1'b0;
      memread_m   = 1'b0;
      execout_m   = '0;
      writedata_m = '0;
      writereg_m  = '0;
   endtask

   // ack_at: REQ cycle (1-based) on which the slave acks; 0 means never.
   task automatic issue(input logic rw, input logic mtr, input logic mw, input logic mr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr,
                        input int ack_at, input logic [31:0] rd,
                        input int exp_stall, input int exp_req);
      wb_t e;
      wb_t g;
      int  st;
      int  rq;
      bit  done;
      regwrite_m  = rw;
      memtoreg_m  = mtr;
      memwrite_m  = mw;
      memread_m   = mr;
      execout_m   = addr;
      writedata_m = wd;
      writereg_m  = wr;
      e.regwrite = rw;
      e.memtoreg = mtr;
      e.execout  = addr;
      e.writereg = wr;
      e.readdata = (mr && !mw && ack_at > 0) ? rd : 32'h0;
      sb.push_back(e);
      st = 0;
      rq = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         dmem_ack   = 1'b0;
         dmem_rdata = 32'hDEAD_BEEF;
         if (dmem_req) begin
            rq++;
            check("dmem_addr", dmem_addr, addr);
            check("dmem_we", {31'b0, dmem_we}, {31'b0, mw});
            if (mw) check("dmem_wdata", dmem_wdata, wd);
            if (rq == ack_at) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rd;
            end
         end
         if (mem_stall) st++;
         else done = 1'b1;
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
         if (!done) begin
            check("bubble_regwrite", {31'b0, regwrite_w}, 32'h0);
            check("bubble_memtoreg", {31'b0, memtoreg_w}, 32'h0);
         end
      end
      check("wb_reached", {31'b0, done}, 32'h1);
      check("stall_cycles", st, exp_stall);
      check("req_cycles", rq, exp_req);
      g = sb.pop_front();
      check("regwrite_w", {31'b0, regwrite_w}, {31'b0, g.regwrite});
      check("memtoreg_w", {31'b0, memtoreg_w}, {31'b0, g.memtoreg});
      check("readdata_w", readdata_w, g.readdata);
      check("execout_w", execout_w, g.execout);
      check("writereg_w", {27'b0, writereg_w}, {27'b0, g.writereg});
      drive_nop();
   endtask

   initial begin
      reset      = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      drive_nop();
      #2;
      check("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
      check("rst_dmem_we", {31'b0, dmem_we}, 32'h0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_dmem_wdata", dmem_wdata, 32'h0);
      check("rst_mem_stall", {31'b0, mem_stall}, 32'h0);
      check("rst_regwrite_w", {31'b0, regwrite_w}, 32'h0);
      check("rst_memtoreg_w", {31'b0, memtoreg_w}, 32'h0);
      check("rst_readdata_w", readdata_w, 32'h0);
      check("rst_execout_w", execout_w, 32'h0);
      check("rst_writereg_w", {27'b0, writereg_w}, 32'h0);
      check("rst_bus_error", {31'b0, bus_error}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Non-memory op: one-cycle pass-through, no stall.
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0, 0, 0);
      // Load acked on the third REQ cycle.
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hCAFE_F00D, 4, 3);
      // Store acked immediately, back to back with the load.
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 1, 32'h1111_2222, 2, 1);
      check("err_before_timeout", {31'b0, bus_error}, 32'h0);
      // Load that is never acked: aborts after 16 REQ cycles.
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd9, 0, 32'h5555_5555, 17, 16);
      check("err_after_timeout", {31'b0, bus_error}, 32'h1);
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0, 5'd12, 0, 32'h0, 0, 0);
      check("err_sticky", {31'b0, bus_error}, 32'h1);

      // Stray ack while idle must not start anything.
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      check("stray_mem_stall", {31'b0, mem_stall}, 32'h0);
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      check("stray_dmem_req", {31'b0, dmem_req}, 32'h0);
      check("stray_readdata_w", readdata_w, 32'h0);

      // Read and write together: the write wins.
      issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0BAD_F00D, 5'd3, 1, 32'h7777_7777, 2, 1);

      // Reset during the second REQ cycle of a load.
      memread_m  = 1'b1;
      memtoreg_m = 1'b1;
      regwrite_m = 1'b1;
      execout_m  = 32'h0000_0500;
      writereg_m = 5'd4;
      @(posedge clk);
      #1;
      check("pre_rst_req1", {31'b0, dmem_req}, 32'h1);
      @(posedge clk);
      #1;
      check("pre_rst_req2", {31'b0, dmem_req}, 32'h1);
      reset = 1'b1;
      drive_nop();
      #1;
      check("midrst_dmem_req", {31'b0, dmem_req}, 32'h0);
      check("midrst_mem_stall", {31'b0, mem_stall}, 32'h0);
      check("midrst_regwrite_w", {31'b0, regwrite_w}, 32'h0);
      check("midrst_readdata_w", readdata_w, 32'h0);
      check("midrst_execout_w", execout_w, 32'h0);
      check("midrst_writereg_w", {27'b0, writereg_w}, 32'h0);
      check("midrst_bus_error", {31'b0, bus_error}, 32'h0);
      @(negedge clk);
      reset      = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFEED_FACE;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      check("late_ack_req", {31'b0, dmem_req}, 32'h0);
      check("late_ack_readdata", readdata_w, 32'h0);
      check("late_ack_stall", {31'b0, mem_stall}, 32'h0);
      @(posedge clk);
      #1;
      check("late_ack_readdata2", readdata_w, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
